camellia_block_sequencer: RTL and testbench
===========================================

# camellia_block_sequencer

Host-side launch/collect controller for the Camellia-128 datapath. It accepts plaintext/key pairs over a valid/ready stream, buffers them in a small FIFO, and issues each pair to the core with a one-cycle `core_data_valid` pulse. It then waits for the core's `core_out_rdy` completion pulse, captures the 128-bit result, and presents it on a valid/ready output stream. It also watches for a missing completion pulse.

## Interface

Parameters:
- `DATA_W`, 128: block and key width.
- `FIFO_DEPTH`, 4: input FIFO entries. Must be a power of 2, ≥2.
- `TIMEOUT`, 40: maximum WAIT cycles before abandoning a block. Must exceed the core latency (28 cycles launch-to-sample).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `in_valid` in 1: host offers a pair.
- `in_ready` out 1: FIFO not full.
- `in_data` in DATA_W: plaintext.
- `in_key` in DATA_W: key.
- `core_data_valid` out 1: one-cycle launch pulse to the core and its latency counter.
- `core_data` out DATA_W: plaintext driven to the core.
- `core_key` out DATA_W: key driven to the core.
- `core_out_rdy` in 1: one-cycle completion pulse from the core.
- `core_result` in DATA_W: core output, valid while `core_out_rdy`=1.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out DATA_W: captured result.
- `busy` out 1: state ≠ IDLE, or FIFO non-empty, or `out_valid`=1.
- `timeout_err` out 1: sticky; a block was abandoned.

## Operation

- **Reset (`rst`=0 at a clock edge):**
  - All outputs go to 0.
  - FIFO pointers and count are cleared; state = IDLE; wait counter = 0.
  - Reset in any state discards the block in flight and all FIFO contents.
- **FIFO:**
  - Width 2·DATA_W, {key, data}.
  - Push when `in_valid && in_ready`; `in_ready` = (count < FIFO_DEPTH), driven combinationally from the registered count.
  - Pop happens only on launch.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count width is clog2(FIFO_DEPTH)+1.
- **FSM, IDLE:**
  - Launch when count > 0 and `out_valid`=0: register `core_data_valid`=1, load `core_data`/`core_key` from the FIFO head, pop, clear the wait counter, go to WAIT.
  - Otherwise `core_data_valid`=0.
- **FSM, WAIT:**
  - `core_data_valid` returns to 0; `core_data`/`core_key` hold their values until the next launch.
  - Each cycle, the wait counter increments.
  - If `core_out_rdy`=1: capture `core_result` into `out_data`, set `out_valid`=1, go to IDLE.
  - Else if the wait counter reaches TIMEOUT−1: set `timeout_err`=1, drop the block, go to IDLE.
- **Output register:**
  - `out_valid` stays high until a cycle with `out_ready`=1, which clears it at that edge.
  - `out_data` holds its value.
- **Ignored inputs:** `core_out_rdy` seen in IDLE is ignored; no state change and no capture.
- **Error flag:** `timeout_err` clears only on reset.
- **Concurrency:** at most one block is in the core at a time.

## Timing

Latency for the first pair into an idle, empty block:
- Push at edge t.
- Launch registered at edge t+1; `core_data_valid` is high for the cycle between t+1 and t+2, and the core samples it at t+2.
- The core's `core_out_rdy` is high between t+29 and t+30; capture occurs at t+30.
- `out_valid`=1 from edge t+30.

Throughput and gating:
- The next launch happens no earlier than the edge after `out_valid` clears.
- Minimum spacing between `core_data_valid` pulses is therefore ≥30 cycles when `out_ready` is held at 1.

Boundary conditions:
- **Back-pressure:** with `out_ready`=0, no new launch occurs; the FIFO fills and `in_ready` drops after FIFO_DEPTH accepted pairs.
- **Timeout:** fires at the TIMEOUT-th WAIT cycle if no completion pulse arrives. A completion pulse on that same cycle wins: the result is captured and there is no error.

## Test plan

- Reset, then push one pair (data=0x0123…CDEF, key=0xFEDC…3210) against the core model (27-cycle counter). Required: `core_data_valid` pulse exactly 1 cycle wide at t+1; `out_valid` at t+30 with `out_data` = model result; `busy` returns to 0 after the output is accepted.
- Push 6 pairs back-to-back with `out_ready`=1. Required: `in_ready` low after 4 entries are queued; all 6 results emerge in order; launches spaced ≥30 cycles; no `timeout_err`.
- Hold `out_ready`=0 for 100 cycles with 3 pairs queued. Required: exactly 1 launch; `out_valid` stays 1 and `out_data` stable; the second launch occurs the edge after `out_ready`=1 is accepted.
- Suppress `core_out_rdy` for one block. Required: `timeout_err`=1 at launch+40; the FSM returns to IDLE and the next queued pair launches normally; `timeout_err` stays 1.
- Assert `rst`=0 while in WAIT with 2 pairs queued. Required: all outputs 0 and the FIFO empty at the next edge; a late `core_out_rdy` after reset is ignored.
- Inject a spurious `core_out_rdy` in IDLE. Required: no `out_valid` and no state change.

Source files
------------

// File: rtl/camellia_block_sequencer.sv
// Purpose: queue plaintext/key pairs, launch them one at a time into the Camellia core, collect each result.
// Latency: launch one edge after a push into an empty idle block; result valid one edge after core_out_rdy.
// Backpressure: in_ready drops when the FIFO is full; no launch while out_valid is held waiting for out_ready.
module camellia_block_sequencer #(
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_key,
    output logic              core_data_valid,
    output logic [DATA_W-1:0] core_data,
    output logic [DATA_W-1:0] core_key,
    input  logic              core_out_rdy,
    input  logic [DATA_W-1:0] core_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              timeout_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WCNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              state;
    logic [2*DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [WCNT_W-1:0]   wait_cnt;
    logic                push;
    logic                launch;

    // A new block only goes out when the core is free and the previous result has been taken.
    assign in_ready = (count < CNT_W'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign launch   = (state == S_IDLE) && (count != '0) && !out_valid;
    assign busy     = (state != S_IDLE) || (count != '0) || out_valid;

    // FIFO storage, {key, data}; contents are discarded on reset by clearing the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_key, in_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of 2.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (launch) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, launch})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Launch/collect FSM with registered core and output-stream signals.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            wait_cnt        <= '0;
            core_data_valid <= 1'b0;
            core_data       <= '0;
            core_key        <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            timeout_err     <= 1'b0;
        end else begin
            core_data_valid <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    // Completion pulses seen here are stray and deliberately ignored.
                    if (launch) begin
                        core_data_valid       <= 1'b1;
                        {core_key, core_data} <= fifo_mem[rd_ptr];
                        wait_cnt              <= '0;
                        state                 <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + WCNT_W'(1);
                    // A completion on the final allowed cycle takes priority over the timeout.
                    if (core_out_rdy) begin
                        out_data  <= core_result;
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end else if (wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_camellia_block_sequencer.sv
// Bench for camellia_block_sequencer: directed vectors against a 27-cycle core model.
// Core result model is data ^ key; expected values in the table are written out by hand.
// Multi-cycle corners (backpressure, timeout, reset in WAIT, stray completion) are hand sequences.
module tb_camellia_block_sequencer;

    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] in_key;
    logic         core_data_valid;
    logic [W-1:0] core_data;
    logic [W-1:0] core_key;
    logic         core_out_rdy;
    logic [W-1:0] core_result;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;

    camellia_block_sequencer #(.DATA_W(W), .FIFO_DEPTH(4), .TIMEOUT(40)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .core_data_valid(core_data_valid), .core_data(core_data), .core_key(core_key),
        .core_out_rdy(core_out_rdy), .core_result(core_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Core model: samples the launch pulse, completes 27 edges later with a one-cycle pulse.
    logic         mact = 1'b0;
    int           mcnt = 0;
    logic [W-1:0] mdata = '0;
    logic [W-1:0] mkey = '0;
    logic         suppress = 1'b0;
    logic         inject = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            mact <= 1'b0;
        end else if (core_data_valid) begin
            mact  <= 1'b1;
            mcnt  <= 27;
            mdata <= core_data;
            mkey  <= core_key;
        end else if (mact) begin
            if (mcnt == 0) mact <= 1'b0;
            else mcnt <= mcnt - 1;
        end
    end

    assign core_out_rdy = (mact && (mcnt == 0) && !suppress) || inject;
    assign core_result  = mdata ^ mkey;

    // Monitors: cycle count, launch times, pulse width, accepted results.
    int           cyc = 0;
    int           launch_q[$];
    logic [W-1:0] got_q[$];
    logic         prev_cdv = 1'b0;
    int           width_err = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            if (core_data_valid) begin
                launch_q.push_back(cyc);
                if (prev_cdv) width_err <= width_err + 1;
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
        end
        prev_cdv <= core_data_valid;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Offer one pair and return at the negedge after the accepting edge.
    task automatic push_pair(input logic [W-1:0] d, input logic [W-1:0] k);
        logic acc;
        logic rdy;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        for (int n = 0; n < 300; n++) begin
            rdy = in_ready;
            @(negedge clk);
            if (rdy) begin
                acc = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        chk1("push_accepted", acc, 1'b1);
    endtask

    task automatic wait_launch(input string name);
        int n;
        n = 0;
        while (!core_data_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk1(name, core_data_valid, 1'b1);
    endtask

    task automatic wait_results(input string name, input int num);
        int n;
        n = 0;
        while (got_q.size() < num && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chki(name, got_q.size(), num);
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] k;
        logic [W-1:0] e;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n;
        int stab_err;
        int seen;

        tbl[0] = '{128'h11111111_22222222_33333333_44444444, 128'h0,
                   128'h11111111_22222222_33333333_44444444};
        tbl[1] = '{128'h0, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5,
                   128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5};
        tbl[2] = '{128'hFFFFFFFF_00000000_FFFFFFFF_00000000, 128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F,
                   128'hF0F0F0F0_0F0F0F0F_F0F0F0F0_0F0F0F0F};
        tbl[3] = '{128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
                   128'hEDCBA987_6543210F_F0123456_789ABCDE};
        tbl[4] = '{128'hDEADBEEF_00000000_00000000_CAFEF00D, 128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF,
                   128'hDEAD4110_0000FFFF_0000FFFF_CAFE0FF2};
        tbl[5] = '{128'h80000000_00000000_00000000_00000000, 128'h00000000_00000000_00000000_00000001,
                   128'h80000000_00000000_00000000_00000001};

        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk1("rst_cdv", core_data_valid, 1'b0);
        chkw("rst_core_data", core_data, '0);
        chkw("rst_core_key", core_key, '0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chkw("rst_out_data", out_data, '0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_timeout_err", timeout_err, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Single pair: launch at t+1 for one cycle, result at t+30.
        in_valid = 1'b1;
        in_data  = 128'h0123456789ABCDEF0123456789ABCDEF;
        in_key   = 128'hFEDCBA9876543210FEDCBA9876543210;
        @(negedge clk);
        in_valid = 1'b0;
        chk1("t1_no_launch_at_push", core_data_valid, 1'b0);
        @(negedge clk);
        chk1("t1_launch", core_data_valid, 1'b1);
        chkw("t1_core_data", core_data, 128'h0123456789ABCDEF0123456789ABCDEF);
        chkw("t1_core_key", core_key, 128'hFEDCBA9876543210FEDCBA9876543210);
        chk1("t1_busy", busy, 1'b1);
        @(negedge clk);
        chk1("t1_pulse_end", core_data_valid, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chki("t1_out_latency", n, 28);
        chkw("t1_out_data", out_data, {128{1'b1}});
        out_ready = 1'b1;
        @(negedge clk);
        chk1("t1_out_cleared", out_valid, 1'b0);
        chk1("t1_busy_idle", busy, 1'b0);
        got_q.delete();
        launch_q.delete();

        // Six pairs back-to-back, results in order.
        for (int i = 0; i < 6; i++) begin
            push_pair(tbl[i].d, tbl[i].k);
            if (i == 4) chk1("t2_in_ready_full", in_ready, 1'b0);
        end
        wait_results("t2_result_count", 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            chkw($sformatf("t2_result_%0d", i), got_q[i], tbl[i].e);
        end
        chki("t2_launch_count", launch_q.size(), 6);
        for (int i = 1; i < launch_q.size(); i++) begin
            chk1($sformatf("t2_spacing_%0d", i), (launch_q[i] - launch_q[i-1]) >= 30, 1'b1);
        end
        chk1("t2_no_timeout", timeout_err, 1'b0);
        @(negedge clk);

        // Backpressure: result held, no second launch until accepted.
        got_q.delete();
        launch_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_pair(tbl[i].d, tbl[i].k);
        stab_err = 0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid && out_data !== tbl[0].e) stab_err++;
        end
        chki("t3_one_launch", launch_q.size(), 1);
        chk1("t3_out_valid_held", out_valid, 1'b1);
        chkw("t3_out_data", out_data, tbl[0].e);
        chki("t3_out_stable", stab_err, 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk1("t3_accept_clears", out_valid, 1'b0);
        chk1("t3_no_launch_at_accept", core_data_valid, 1'b0);
        @(negedge clk);
        chk1("t3_second_launch", core_data_valid, 1'b1);
        chkw("t3_second_data", core_data, tbl[1].d);
        wait_results("t3_result_count", 3);
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            chkw($sformatf("t3_result_%0d", i), got_q[i], tbl[i].e);
        end
        @(negedge clk);

        // Completion on the final allowed WAIT cycle beats the timeout.
        got_q.delete();
        suppress = 1'b1;
        push_pair(tbl[3].d, tbl[3].k);
        wait_launch("t5_launch");
        repeat (39) @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        chk1("t5_captured", out_valid, 1'b1);
        chkw("t5_out_data", out_data, tbl[3].e);
        chk1("t5_no_timeout", timeout_err, 1'b0);
        @(negedge clk);

        // Missing completion: error at launch+40, next pair launches normally.
        got_q.delete();
        push_pair(tbl[4].d, tbl[4].k);
        push_pair(tbl[5].d, tbl[5].k);
        wait_launch("t4_launch");
        n = 0;
        while (!timeout_err && n < 80) begin
            @(negedge clk);
            n++;
        end
        chki("t4_timeout_cycle", n, 40);
        chk1("t4_no_capture", out_valid, 1'b0);
        suppress = 1'b0;
        @(negedge clk);
        chk1("t4_next_launch", core_data_valid, 1'b1);
        chkw("t4_next_data", core_data, tbl[5].d);
        wait_results("t4_result_count", 1);
        if (got_q.size() > 0) chkw("t4_result", got_q[0], tbl[5].e);
        chk1("t4_err_sticky", timeout_err, 1'b1);
        @(negedge clk);

        // Reset during WAIT with two pairs queued.
        for (int i = 0; i < 3; i++) push_pair(tbl[i].d, tbl[i].k);
        repeat (5) @(negedge clk);
        chk1("t6_busy_before", busy, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk1("t6_cdv", core_data_valid, 1'b0);
        chkw("t6_core_data", core_data, '0);
        chkw("t6_core_key", core_key, '0);
        chk1("t6_out_valid", out_valid, 1'b0);
        chkw("t6_out_data", out_data, '0);
        chk1("t6_timeout_err", timeout_err, 1'b0);
        chk1("t6_busy", busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Stray completion in IDLE (late pulse after reset): nothing happens.
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (core_data_valid || out_valid) seen++;
        end
        chki("t7_no_activity", seen, 0);
        chkw("t7_out_data", out_data, '0);
        chk1("t7_busy", busy, 1'b0);
        chki("pulse_width", width_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
